// File: rtl/chunk_compare.sv
// Magnitude comparator that walks the operands CHUNK bits per cycle, MSB chunk first, in signed or unsigned mode.
// Latency: done pulses k cycles after the start edge, k = chunks examined (1..NCHUNK); stops at the first differing chunk.
// Backpressure: none; start is only sampled in IDLE and is dropped, not queued, while a compare is in flight.
module chunk_compare #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             LT,
    output logic             GT,
    output logic             EQ
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sm_r;
    logic [IDXW-1:0]    idx;

    logic [WIDTH-1:0]   msb_mask;
    logic [WIDTH-1:0]   a_k;
    logic [WIDTH-1:0]   b_k;
    logic [CHUNK-1:0]   a_c;
    logic [CHUNK-1:0]   b_c;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        msb_mask = {sm_r, {(WIDTH-1){1'b0}}};
        a_k      = a_r ^ msb_mask;
        b_k      = b_r ^ msb_mask;
        a_c      = a_k[idx*CHUNK +: CHUNK];
        b_c      = b_k[idx*CHUNK +: CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            LT    <= 1'b0;
            GT    <= 1'b0;
            EQ    <= 1'b0;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            sm_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sm_r  <= signed_mode;
                        LT    <= 1'b0;
                        GT    <= 1'b0;
                        EQ    <= 1'b0;
                        idx   <= IDXW'(NCHUNK - 1);
                        state <= COMPARE;
                        busy  <= 1'b1;
                    end
                end
                COMPARE: begin
                    if (a_c != b_c) begin
                        GT    <= (a_c > b_c);
                        LT    <= !(a_c > b_c);
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (idx == '0) begin
                        EQ    <= 1'b1;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
